// File: rtl/ahb_dsi_pkg.sv
// Shared types and constants for the AHB-Lite DSI configuration responder.
// Build option AHB_DSI_CFG_BYTE_WR_EN enables byte/halfword writes.
package ahb_dsi_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } dsi_state_e;

   localparam logic [31:0] DSI_ID_DEFAULT = 32'hD510_0001;

   // Byte lanes touched by a naturally aligned transfer of the given size.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         HSIZE_BYTE: return 4'b0001 << lo;
         HSIZE_HALF: return 4'b0011 << lo;
         default:    return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_dsi_cfg_regfile.sv
// DSI configuration register storage: byte-lane writes, write strobes, read mux.
// Register 0 is a read-only identification constant.
module ahb_dsi_cfg_regfile
   import ahb_dsi_pkg::*;
#(
   parameter int          NUM_REGS = 8,
   parameter int          ADDR_W   = 3,
   parameter logic [31:0] ID_VALUE = DSI_ID_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      widx,
   input  logic [3:0]             wbe,
   input  logic [31:0]            wdata,
   input  logic [ADDR_W-1:0]      ridx,
   output logic [31:0]            rdata,
   output logic [NUM_REGS*32-1:0] cfg_regs,
   output logic [NUM_REGS-1:0]    cfg_wr_pulse
);

   logic [31:0] regs [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0) begin : g_id
            assign regs[gi]         = ID_VALUE;
            assign cfg_wr_pulse[gi] = 1'b0;
         end else begin : g_rw
            logic [31:0] val_reg;
            logic        pulse_reg;
            logic        hit;

            assign hit = we && (widx == ADDR_W'(gi));

            always_ff @(posedge clk) begin
               if (rst) begin
                  val_reg   <= '0;
                  pulse_reg <= 1'b0;
               end else begin
                  pulse_reg <= hit;
                  for (int b = 0; b < 4; b++) begin
                     if (hit && wbe[b]) val_reg[8*b +: 8] <= wdata[8*b +: 8];
                  end
               end
            end

            assign regs[gi]         = val_reg;
            assign cfg_wr_pulse[gi] = pulse_reg;
         end
         assign cfg_regs[32*gi +: 32] = regs[gi];
      end
   endgenerate

   // Compare-based mux so a non-power-of-two bank never indexes past the array.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ridx == ADDR_W'(i)) rdata = regs[i];
      end
   end

endmodule

// File: rtl/ahb_dsi_cfg_slave.sv
// AHB-Lite responder for the MIPI DSI configuration register bank.
// Build option AHB_DSI_CFG_BYTE_WR_EN allows aligned byte/halfword transfers.
module ahb_dsi_cfg_slave
   import ahb_dsi_pkg::*;
#(
   parameter int          NUM_REGS    = 8,
   parameter int          ADDR_W      = 3,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = DSI_ID_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hsel,
   input  logic [31:0]            haddr,
   input  logic                   hwrite,
   input  logic [2:0]             hsize,
   input  logic [2:0]             hburst,
   input  logic [1:0]             htrans,
   input  logic [31:0]            hwdata,
   input  logic [3:0]             hprot,
   input  logic                   hready,
   output logic                   hreadyout,
   output logic [1:0]             hresp,
   output logic [31:0]            hrdata,
   output logic [NUM_REGS*32-1:0] cfg_regs,
   output logic [NUM_REGS-1:0]    cfg_wr_pulse
);

   localparam logic [3:0] WS_L = 4'(WAIT_STATES);

   dsi_state_e        state_reg;
   logic [3:0]        cnt_reg;
   logic [ADDR_W-1:0] idx_reg;
   logic              write_reg;
   logic [3:0]        be_reg;
   logic              hreadyout_reg;
   logic [1:0]        hresp_reg;

   logic              accept;
   logic [ADDR_W-1:0] a_idx;
   logic              a_region_err;
   logic              a_range_err;
   logic              a_size_err;
   logic              a_err;
   logic [3:0]        a_be;
   logic [31:0]       rf_rdata;
   logic              unused_inputs;

   assign unused_inputs = ^{hburst, hprot, htrans[0]};

   assign accept       = hsel && hready && htrans[1];
   assign a_idx        = haddr[ADDR_W+1:2];
   assign a_region_err = haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];

   genvar gi;
   generate
      if (NUM_REGS < (1 << ADDR_W)) begin : g_range
         assign a_range_err = {1'b0, a_idx} >= (ADDR_W+1)'(NUM_REGS);
      end else begin : g_no_range
         assign a_range_err = 1'b0;
      end
   endgenerate

`ifdef AHB_DSI_CFG_BYTE_WR_EN
   always_comb begin
      a_be       = byte_lanes(hsize, haddr[1:0]);
      a_size_err = 1'b1;
      case (hsize)
         HSIZE_BYTE: a_size_err = 1'b0;
         HSIZE_HALF: a_size_err = haddr[0];
         HSIZE_WORD: a_size_err = haddr[1:0] != 2'b00;
         default:    a_size_err = 1'b1;
      endcase
   end
`else
   assign a_be       = 4'hF;
   assign a_size_err = (hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00);
`endif

   assign a_err = a_region_err || a_range_err || a_size_err;

   // New address phases are only looked at when the previous data phase is ending.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         write_reg     <= 1'b0;
         be_reg        <= '0;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= HRESP_OKAY;
      end else begin
         case (state_reg)
            ST_WAIT: begin
               if (cnt_reg <= 4'd1) begin
                  state_reg     <= ST_DATA;
                  hreadyout_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_ERR1: begin
               state_reg     <= ST_ERR2;
               hreadyout_reg <= 1'b1;
               hresp_reg     <= HRESP_ERROR;
            end
            default: begin
               if (accept) begin
                  idx_reg   <= a_idx;
                  write_reg <= hwrite;
                  be_reg    <= a_be;
                  if (a_err) begin
                     state_reg     <= ST_ERR1;
                     hreadyout_reg <= 1'b0;
                     hresp_reg     <= HRESP_ERROR;
                  end else if (WS_L != 4'd0) begin
                     state_reg     <= ST_WAIT;
                     cnt_reg       <= WS_L;
                     hreadyout_reg <= 1'b0;
                     hresp_reg     <= HRESP_OKAY;
                  end else begin
                     state_reg     <= ST_DATA;
                     hreadyout_reg <= 1'b1;
                     hresp_reg     <= HRESP_OKAY;
                  end
               end else begin
                  state_reg     <= ST_IDLE;
                  hreadyout_reg <= 1'b1;
                  hresp_reg     <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   ahb_dsi_cfg_regfile #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ID_VALUE (ID_VALUE)
   ) u_regfile (
      .clk          (clk),
      .rst          (rst),
      .we           ((state_reg == ST_DATA) && write_reg),
      .widx         (idx_reg),
      .wbe          (be_reg),
      .wdata        (hwdata),
      .ridx         (idx_reg),
      .rdata        (rf_rdata),
      .cfg_regs     (cfg_regs),
      .cfg_wr_pulse (cfg_wr_pulse)
   );

   assign hreadyout = hreadyout_reg;
   assign hresp     = hresp_reg;
   assign hrdata    = (((state_reg == ST_WAIT) || (state_reg == ST_DATA)) && !write_reg)
                      ? rf_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_dsi_cfg_slave.sv
// Bench for ahb_dsi_cfg_slave: one zero-wait and one two-wait instance share a
// muxed AHB bus and are checked against an array-based register model.
module tb_ahb_dsi_cfg_slave;

   localparam logic [31:0] ID   = 32'hD510_0001;
   localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef AHB_DSI_CFG_BYTE_WR_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic [3:0]  hprot;
   logic        hold_low;
   logic        use2;

   logic         ro0, ro2;
   logic [1:0]   rp0, rp2;
   logic [31:0]  rd0, rd2;
   logic [255:0] regs0, regs2;
   logic [7:0]   pulse0, pulse2;

   logic         hsel0, hsel2, hready_bus;
   logic         b_ready;
   logic [1:0]   b_resp;
   logic [31:0]  b_rdata;
   logic [255:0] b_regs;
   logic [7:0]   b_pulse;

   logic [31:0] m0 [8];
   logic [31:0] m2 [8];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign hsel0      = hsel & ~use2;
   assign hsel2      = hsel & use2;
   assign b_ready    = use2 ? ro2 : ro0;
   assign b_resp     = use2 ? rp2 : rp0;
   assign b_rdata    = use2 ? rd2 : rd0;
   assign b_regs     = use2 ? regs2 : regs0;
   assign b_pulse    = use2 ? pulse2 : pulse0;
   assign hready_bus = hold_low ? 1'b0 : b_ready;

   ahb_dsi_cfg_slave #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
      .hprot(hprot), .hready(hready_bus), .hreadyout(ro0), .hresp(rp0),
      .hrdata(rd0), .cfg_regs(regs0), .cfg_wr_pulse(pulse0)
   );

   ahb_dsi_cfg_slave #(.WAIT_STATES(2)) dut2 (
      .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
      .hprot(hprot), .hready(hready_bus), .hreadyout(ro2), .hresp(rp2),
      .hrdata(rd2), .cfg_regs(regs2), .cfg_wr_pulse(pulse2)
   );

   function automatic logic [31:0] model_get(input bit s2, input int i);
      return s2 ? m2[i] : m0[i];
   endfunction

   function automatic logic [255:0] model_flat(input bit s2);
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[32*i +: 32] = s2 ? m2[i] : m0[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m0[i] = (i == 0) ? ID : 32'h0;
         m2[i] = (i == 0) ? ID : 32'h0;
      end
   endtask

   task automatic bus_idle();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
   endtask

   // Single isolated transfer: address phase, full data phase, then two idle cycles.
   task automatic do_xfer(input bit sel2, input logic [31:0] addr, input bit wr,
                          input logic [2:0] size, input logic [31:0] wdata, input string tag);
      bit           err;
      int           idx, ws, waits, lo, nb, sz;
      logic [31:0]  exp_rd, cur;
      logic [7:0]   exp_pulse;
      logic [1:0]   exp_resp;
      sz  = int'(size);
      idx = int'((addr / 4) % 8);
      err = ((addr / 32) != (BASE / 32)) || ((addr % (1 << sz)) != 0)
            || !(sz == 2 || (BYTE_EN && sz < 2));
      ws       = sel2 ? 2 : 0;
      exp_rd   = (!wr && !err) ? model_get(sel2, idx) : 32'h0;
      exp_resp = err ? 2'b01 : 2'b00;

      use2 = sel2; hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size;
      htrans = 2'b10; hburst = 3'($urandom); hprot = 4'($urandom);
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wdata; haddr = $urandom;

      waits = 0;
      while (b_ready !== 1'b1 && waits < 40) begin
         n_cmp++;
         if (b_resp !== exp_resp) begin
            n_err++;
            $display("FAIL %s wait_resp: got %b want %b", tag, b_resp, exp_resp);
         end
         n_cmp++;
         if (b_rdata !== exp_rd) begin
            n_err++;
            $display("FAIL %s wait_rdata: got %h want %h", tag, b_rdata, exp_rd);
         end
         waits++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (waits != (err ? 1 : ws)) begin
         n_err++;
         $display("FAIL %s wait_count: got %0d want %0d", tag, waits, err ? 1 : ws);
      end
      n_cmp++;
      if (b_resp !== exp_resp) begin
         n_err++;
         $display("FAIL %s final_resp: got %b want %b", tag, b_resp, exp_resp);
      end
      n_cmp++;
      if (b_rdata !== exp_rd) begin
         n_err++;
         $display("FAIL %s rdata: got %h want %h", tag, b_rdata, exp_rd);
      end

      exp_pulse = 8'h0;
      if (wr && !err && idx != 0) begin
         cur = model_get(sel2, idx);
         lo  = int'(addr % 4);
         nb  = 1 << sz;
         for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + nb) cur[8*b +: 8] = wdata[8*b +: 8];
         end
         if (sel2) m2[idx] = cur; else m0[idx] = cur;
         exp_pulse = 8'(1 << idx);
      end

      @(posedge clk); #1;
      n_cmp++;
      if (b_pulse !== exp_pulse) begin
         n_err++;
         $display("FAIL %s pulse: got %b want %b", tag, b_pulse, exp_pulse);
      end
      n_cmp++;
      if (b_regs !== model_flat(sel2)) begin
         n_err++;
         $display("FAIL %s regs: got %h want %h", tag, b_regs, model_flat(sel2));
      end
      @(posedge clk); #1;
      n_cmp++;
      if (b_pulse !== 8'h0) begin
         n_err++;
         $display("FAIL %s pulse_len: got %b want 00000000", tag, b_pulse);
      end
      $display("xfer %-10s dut%0d %s addr=%h size=%0d wdata=%h rdata=%h err=%0d waits=%0d",
               tag, sel2 ? 2 : 0, wr ? "WR" : "RD", addr, sz, wdata, exp_rd, err, waits);
   endtask

   task automatic test_reset();
      rst = 1'b1; hold_low = 1'b0; use2 = 1'b0; hwdata = 32'h0; haddr = 32'h0;
      hburst = 3'b000; hprot = 4'h0;
      bus_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         use2 = (d == 1);
         #0;
         n_cmp++;
         if ({b_ready, b_resp, b_rdata, b_pulse} !== {1'b1, 2'b00, 32'h0, 8'h0}) begin
            n_err++;
            $display("FAIL reset_outputs dut%0d: got rdy=%b resp=%b rd=%h pulse=%b want 1/00/0/0",
                     d * 2, b_ready, b_resp, b_rdata, b_pulse);
         end
         n_cmp++;
         if (b_regs !== model_flat(use2)) begin
            n_err++;
            $display("FAIL reset_regs dut%0d: got %h want %h", d * 2, b_regs, model_flat(use2));
         end
         $display("reset check dut%0d regs=%h", d * 2, b_regs);
      end
      use2 = 1'b0;
   endtask

   task automatic test_write_read();
      do_xfer(1'b0, 32'h4, 1'b1, 3'b010, 32'hA5A5_5A5A, "wr_0x4");
      do_xfer(1'b0, 32'h4, 1'b0, 3'b010, 32'h0, "rd_0x4");
   endtask

   task automatic test_wait_states();
      do_xfer(1'b1, 32'h8, 1'b1, 3'b010, 32'h1234_5678, "ws_wr_0x8");
      do_xfer(1'b1, 32'h8, 1'b0, 3'b010, 32'h0, "ws_rd_0x8");
   endtask

   task automatic test_errors();
      do_xfer(1'b0, 32'h40, 1'b0, 3'b010, 32'h0, "rd_0x40");
      do_xfer(1'b1, 32'h40, 1'b1, 3'b010, 32'hFFFF_FFFF, "wr_0x40");
      do_xfer(1'b0, 32'h6, 1'b1, 3'b010, 32'hDEAD_BEEF, "wr_unalign");
      do_xfer(1'b0, 32'hC, 1'b1, 3'b010, 32'hCAFE_F00D, "wr_0xC");
      do_xfer(1'b0, 32'hC, 1'b1, 3'b000, 32'h0000_0077, "byte_0xC");
      do_xfer(1'b0, 32'hC, 1'b0, 3'b010, 32'h0, "rd_0xC");
   endtask

   task automatic test_reg0_readonly();
      do_xfer(1'b0, 32'h0, 1'b1, 3'b010, 32'hFFFF_FFFF, "wr_reg0");
      do_xfer(1'b0, 32'h0, 1'b0, 3'b010, 32'h0, "rd_reg0");
   endtask

   task automatic test_back_to_back();
      int          n;
      logic [31:0] val;
      for (int k = 0; k < 3; k++) begin
         n   = $urandom_range(1, 7);
         val = $urandom;
         use2 = 1'b0; hsel = 1'b1; haddr = 32'(n * 4); hwrite = 1'b1; hsize = 3'b010;
         htrans = 2'b10;
         @(posedge clk); #1;
         hwdata = val; hwrite = 1'b0; htrans = 2'b10;
         @(posedge clk); #1;
         hsel = 1'b0; htrans = 2'b00;
         m0[n] = val;
         n_cmp++;
         if ({b_ready, b_resp, b_rdata} !== {1'b1, 2'b00, val}) begin
            n_err++;
            $display("FAIL b2b_read reg%0d: got rdy=%b resp=%b rd=%h want 1/00/%h",
                     n, b_ready, b_resp, b_rdata, val);
         end
         n_cmp++;
         if (b_pulse !== 8'(1 << n)) begin
            n_err++;
            $display("FAIL b2b_pulse reg%0d: got %b want %b", n, b_pulse, 8'(1 << n));
         end
         @(posedge clk); #1;
         n_cmp++;
         if ({b_pulse, b_rdata} !== 40'h0) begin
            n_err++;
            $display("FAIL b2b_after reg%0d: got pulse=%b rd=%h want 0/0", n, b_pulse, b_rdata);
         end
         $display("b2b reg%0d wr/rd %h", n, val);
      end
   endtask

   task automatic test_hready_low();
      use2 = 1'b0; hold_low = 1'b1;
      hsel = 1'b1; haddr = 32'h8; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
      @(posedge clk); #1;
      bus_idle(); hold_low = 1'b0; hwdata = 32'h5555_AAAA;
      n_cmp++;
      if (b_ready !== 1'b1) begin
         n_err++;
         $display("FAIL hready_low_ready: got %b want 1", b_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({b_pulse, b_regs} !== {8'h0, model_flat(1'b0)}) begin
         n_err++;
         $display("FAIL hready_low_ignored: got pulse=%b regs=%h want 0 / %h",
                  b_pulse, b_regs, model_flat(1'b0));
      end
      $display("hready_low address phase ignored check done");
   endtask

   task automatic test_reset_mid_transfer();
      use2 = 1'b1;
      hsel = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
      @(posedge clk); #1;
      bus_idle(); hwdata = 32'hDEAD_BEEF;
      n_cmp++;
      if (b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_wait: got rdy=%b want 0", b_ready);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      n_cmp++;
      if ({b_ready, b_resp, b_pulse} !== {1'b1, 2'b00, 8'h0}) begin
         n_err++;
         $display("FAIL rst_mid_out: got rdy=%b resp=%b pulse=%b want 1/00/0",
                  b_ready, b_resp, b_pulse);
      end
      repeat (3) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({b_pulse, b_regs[128 +: 32]} !== 40'h0) begin
            n_err++;
            $display("FAIL rst_mid_reg4: got pulse=%b reg4=%h want 0/0", b_pulse, b_regs[128 +: 32]);
         end
      end
      $display("reset during WAIT of write to 0x10 discarded");
   endtask

   task automatic test_random();
      int          idx, kind, sz;
      logic [31:0] addr;
      bit          s2, wr;
      for (int t = 0; t < 40; t++) begin
         s2   = 1'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         idx  = $urandom_range(0, 7);
         kind = $urandom_range(0, 9);
         sz   = 2;
         addr = 32'(idx * 4);
         if (kind == 0) begin
            addr = 32'h0000_1000 | addr;
         end else if (kind == 1) begin
            addr = addr + 32'($urandom_range(1, 3));
         end else if (kind == 2) begin
            sz   = $urandom_range(0, 1);
            addr = addr + 32'((sz == 0) ? $urandom_range(0, 3) : 2 * $urandom_range(0, 1));
         end
         do_xfer(s2, addr, wr, 3'(sz), $urandom, "random");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_wait_states();
      test_errors();
      test_reg0_readonly();
      test_back_to_back();
      test_hready_low();
      test_reset_mid_transfer();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
